// File: rtl/phase_shift_scheduler.sv
// Phase shift command scheduler: queues {pll, periods} commands and hands them
// one at a time to a PLL shift processor, tracking its phasestep pulses to
// detect completion or abandonment.
module phase_shift_scheduler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    input  logic                          i_cmd_pll,
    input  logic [7:0]                    i_cmd_periods,
    output logic                          o_cmd_ready,
    output logic                          o_ready,
    output logic                          o_pll_to_update,
    output logic [7:0]                    o_periods_to_process,
    input  logic                          i_phasestep,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

    typedef struct packed {
        logic       pll;
        logic [7:0] periods;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_GUARD
    } state_t;

    cmd_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic           cmd_ready_q;

    state_t         state_q, state_d;
    logic [7:0]     step_q, step_d;
    logic [15:0]    idle_q, idle_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic           ph_prev_q;

    logic           pll_q;
    logic [7:0]     periods_q;
    logic           ready_q, busy_q, done_q, timeout_q;
    logic           timeout_d;

    logic           push_c, pop_c, rise_c;

    // Zero-length commands are swallowed at the door; full is judged on the current level only.
    assign push_c = i_cmd_valid && cmd_ready_q && (i_cmd_periods != 8'd0);
    assign rise_c = i_phasestep && !ph_prev_q;

    // Queue occupancy bookkeeping.
    always_comb begin
        level_d = level_q;
        unique case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Command storage; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pll: i_cmd_pll, periods: i_cmd_periods};
        end
    end

    // Queue pointers, level and acceptance flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q     <= level_d;
            cmd_ready_q <= (level_d < LW'(FIFO_DEPTH));
        end
    end

    // Dispatch FSM next-state logic with step, idle and guard counters.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        idle_d    = idle_q;
        guard_d   = guard_q;
        pop_c     = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop_c   = 1'b1;
                    step_d  = 8'd0;
                    idle_d  = 16'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rise_c) begin
                    step_d  = 8'd1;
                    idle_d  = 16'd0;
                    state_d = S_WAIT;
                end else if (idle_q == 16'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    guard_d   = '0;
                    state_d   = S_GUARD;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            S_WAIT: begin
                if ((step_q == periods_q) && !i_phasestep) begin
                    state_d = S_FINISH;
                end else if (rise_c) begin
                    if (step_q != 8'hFF) step_d = step_q + 8'd1;
                    idle_d = 16'd0;
                end else if (idle_q == 16'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    guard_d   = '0;
                    state_d   = S_GUARD;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            S_FINISH: begin
                guard_d = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, counters, edge history and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= 8'd0;
            idle_q    <= 16'd0;
            guard_q   <= '0;
            ph_prev_q <= 1'b0;
            pll_q     <= 1'b0;
            periods_q <= 8'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            idle_q    <= idle_d;
            guard_q   <= guard_d;
            ph_prev_q <= i_phasestep;
            if (pop_c) begin
                pll_q     <= mem_q[rd_ptr_q].pll;
                periods_q <= mem_q[rd_ptr_q].periods;
            end
            ready_q   <= (state_d == S_ISSUE);
            busy_q    <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_FINISH);
            done_q    <= (state_d == S_FINISH);
            timeout_q <= timeout_d;
        end
    end

    assign o_cmd_ready          = cmd_ready_q;
    assign o_ready              = ready_q;
    assign o_pll_to_update      = pll_q;
    assign o_periods_to_process = periods_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_timeout            = timeout_q;
    assign o_fifo_level         = level_q;

endmodule

// File: doc/phase_shift_scheduler.md
PHASE_SHIFT_SCHEDULER -- requirements
Module: phase_shift_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue depth; SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: idle-cycle limit per command; SHALL be at least 1 and at most 65535.
REQ-003 Parameter GUARD_CYCLES, default 2: quiet cycles after each command; SHALL be at least 1.
REQ-004 Ports (name, direction, width, meaning):
- i_clk, in, 1: sole clock; all logic rising-edge.
- i_rst_n, in, 1: synchronous active-low reset.
- i_cmd_valid, in, 1: command offered.
- i_cmd_pll, in, 1: target PLL index.
- i_cmd_periods, in, 8: phase steps requested.
- o_cmd_ready, out, 1: queue can accept.
- o_ready, out, 1: dispatch request to the shift processor.
- o_pll_to_update, out, 1: PLL index to the shift processor.
- o_periods_to_process, out, 8: step count to the shift processor.
- i_phasestep, in, 1: shift processor phasestep output, monitored.
- o_busy, out, 1: a command is in flight.
- o_done, out, 1: one-cycle pulse when a command completes.
- o_timeout, out, 1: one-cycle pulse when a command is abandoned.
- o_fifo_level, out, clog2(FIFO_DEPTH)+1: queued command count.

Function
REQ-005 A command SHALL be accepted on a cycle where i_cmd_valid and o_cmd_ready are both 1; {i_cmd_pll, i_cmd_periods} SHALL be written to the FIFO tail.
REQ-006 o_cmd_ready SHALL be 1 exactly when o_fifo_level is less than FIFO_DEPTH; a same-cycle pop SHALL NOT free space for a push when full.
REQ-007 An accepted command with i_cmd_periods equal to 0 SHALL be discarded without a queue write or an o_done pulse.
REQ-008 FIFO pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_level SHALL change by +1, -1, or 0 on push only, pop only, or both.
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT, FINISH and GUARD.
REQ-010 IDLE: when the FIFO is not empty, the FSM SHALL pop the head, latch it into o_pll_to_update and o_periods_to_process, and go to ISSUE on the next cycle.
REQ-011 ISSUE: o_ready SHALL be 1 until the first rising edge of i_phasestep is sampled; that edge SHALL count as step 1, and the FSM SHALL then go to WAIT.
REQ-012 A rising edge SHALL be i_phasestep at 1 while its registered previous value is 0; the 8-bit step counter SHALL NOT wrap.
REQ-013 WAIT: the FSM SHALL count rising edges; when the count equals o_periods_to_process and i_phasestep is 0, it SHALL go to FINISH.
REQ-014 FINISH: o_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to GUARD.
REQ-015 GUARD: the FSM SHALL wait GUARD_CYCLES cycles with o_ready at 0 (this lets the processor return to its listen state), then go to IDLE.
REQ-016 A 16-bit idle counter SHALL clear on every sampled edge and on ISSUE entry; it SHALL increment otherwise in ISSUE and WAIT.
REQ-017 When the idle counter reaches TIMEOUT_CYCLES, o_timeout SHALL pulse for one cycle, o_ready SHALL drop, the command SHALL be dropped with no o_done, and the FSM SHALL enter GUARD.
REQ-018 Edges sampled in IDLE, FINISH or GUARD SHALL be ignored.
REQ-019 o_busy SHALL be 1 in ISSUE, WAIT and FINISH, and 0 otherwise.
REQ-020 o_pll_to_update and o_periods_to_process SHALL stay stable from latch until the next pop.
REQ-021 Minimum dispatch latency SHALL be 2 cycles from push into an empty idle block to o_ready at 1.

Reset
REQ-022 While i_rst_n is 0 at a rising i_clk edge, the FSM SHALL go to IDLE, the FIFO SHALL empty, and all counters and the previous-edge register SHALL clear.
REQ-023 Reset values: o_ready 0, o_pll_to_update 0, o_periods_to_process 0, o_busy 0, o_done 0, o_timeout 0, o_fifo_level 0, o_cmd_ready 1.
REQ-024 Reset asserted mid-command SHALL abandon the command with no o_done and no o_timeout pulse.

Verification
REQ-025 Push {pll=1, periods=3}, then drive 3 phasestep pulses -> o_ready at 1 two cycles after the push, o_pll_to_update=1, o_periods_to_process=3, o_done pulses once after the third pulse falls.
REQ-026 Push 5 commands while busy with FIFO_DEPTH=4 -> 4 accepted, o_cmd_ready 0 on the fifth, all 4 dispatched in order.
REQ-027 Push {pll=0, periods=0} -> no o_ready, no o_done, o_fifo_level stays 0.
REQ-028 Push {pll=0, periods=2} with phasestep held at 0 -> o_timeout pulses after TIMEOUT_CYCLES cycles, no o_done, and the next command dispatches after GUARD_CYCLES.
REQ-029 Reset in WAIT after 1 of 4 steps -> all outputs at reset values on the next cycle, and a later push dispatches normally.
REQ-030 Push and pop in the same cycle at level 2 -> level stays 2; wrap-around over 10 commands -> order preserved.
